ca_code_nco_gen: RTL and testbench

CA_CODE_NCO_GEN -- requirements
Module: ca_code_nco_gen

---
 rtl/ca_pkg.sv | 41 ++++
 rtl/ca_code_nco.sv | 39 +++
 rtl/ca_code_nco_gen.sv | 166 ++++++++++++++++
 tb/tb_ca_code_nco_gen.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ca_pkg
//  Description : Shared definitions for the GPS C/A code generator.
//                CODE_LEN and LFSR_INIT describe the Gold code.
//                PRN_TAPS holds the G2 phase-selector tap pairs for
//                PRN1..PRN32, packed as {tapA, tapB} in nibbles, stages 1..10.
//                prn_g2_mask turns a tap pair into a 10-bit mask with bit
//                (stage-1) set. ca_state_e is the generator FSM state.
//  Revision    : 1.0 - initial release
// ============================================================================
package ca_pkg;

    localparam int         CODE_LEN  = 1023;
    localparam logic [9:0] LFSR_INIT = 10'h3FF;
    localparam logic [9:0] LAST_CHIP = 10'(CODE_LEN - 1);

    localparam logic [7:0] PRN_TAPS [32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
        8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
    };

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_SLEW = 1'b1
    } ca_state_e;

    // The two taps are always distinct, so the chip XOR reduces to the
    // parity of (G2 & mask).
    function automatic logic [9:0] prn_g2_mask(input logic [4:0] prn);
        logic [3:0] ta;
        logic [3:0] tb;
        ta = PRN_TAPS[prn][7:4];
        tb = PRN_TAPS[prn][3:0];
        return (10'd1 << (ta - 4'd1)) | (10'd1 << (tb - 4'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ca_code_nco.sv
`default_nettype none
// ============================================================================
//  Module      : ca_code_nco
//  Description : Phase-accumulator NCO. Adds rate modulo 2^ACC_WIDTH each
//                enabled cycle. tick is the carry-out of that add. tick is
//                combinational so the owner can act on it in the same cycle.
//  Ports       : clk, reset (async, active high), enable, clear (sync
//                zeroing, wins over enable), rate [ACC_WIDTH], tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module ca_code_nco #(
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [ACC_WIDTH-1:0] rate,
    output logic                 tick
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, rate};
    assign tick  = enable & ~clear & w_sum[ACC_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (enable) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ca_code_nco_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ca_code_nco_gen
//  Description : GPS C/A code generator driven by a code NCO. It produces
//                early/prompt/late chips spaced half a chip apart, the chip
//                index, and an epoch pulse and counter. A load selects the
//                PRN and slews the generator to a target chip at one chip
//                per clock.
//  Ports       : clk, reset (async, active high), enable, code_rate,
//                prn, load, load_phase ->
//                early, prompt, late, code_phase, half_chip, epoch,
//                epoch_count, busy
//  Revision    : 1.0 - initial release
// ============================================================================
module ca_code_nco_gen
    import ca_pkg::*;
#(
    parameter int ACC_WIDTH = 24,
    parameter int EPOCH_MOD = 20,
    parameter int EPOCH_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] code_rate,
    input  logic [4:0]           prn,
    input  logic                 load,
    input  logic [9:0]           load_phase,
    output logic                 early,
    output logic                 prompt,
    output logic                 late,
    output logic [9:0]           code_phase,
    output logic                 half_chip,
    output logic                 epoch,
    output logic [EPOCH_W-1:0]   epoch_count,
    output logic                 busy
);

    localparam logic [9:0] MASK_PRN1 = prn_g2_mask(5'd0);

    ca_state_e          r_state;
    ca_state_e          w_state_nxt;
    logic [9:0]         r_g1;
    logic [9:0]         r_g2;
    logic [9:0]         r_mask;
    logic [9:0]         r_phase;
    logic [9:0]         r_target;
    logic               r_half;
    logic               r_early;
    logic               r_prompt;
    logic               r_late;
    logic               r_epoch;
    logic [EPOCH_W-1:0] r_epoch_cnt;

    logic               w_chip;
    logic [9:0]         w_g1_nxt;
    logic [9:0]         w_g2_nxt;
    logic [9:0]         w_phase_inc;
    logic [9:0]         w_target_sat;
    logic               w_nco_en;
    logic               w_tick;
    logic               w_wrap;

    // Bit k holds stage k+1. A shift toward stage 10 moves data to higher bits.
    assign w_g1_nxt = {r_g1[8:0], r_g1[2] ^ r_g1[9]};
    assign w_g2_nxt = {r_g2[8:0], r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9]};
    assign w_chip   = r_g1[9] ^ (^(r_g2 & r_mask));

    assign w_phase_inc  = (r_phase == LAST_CHIP) ? 10'd0 : r_phase + 10'd1;
    assign w_target_sat = (load_phase > LAST_CHIP) ? LAST_CHIP : load_phase;

    // The NCO only runs in RUN. It is frozen at zero through a slew.
    assign w_nco_en = enable & (r_state == ST_RUN) & ~load;
    assign w_wrap   = w_tick & r_half & (r_phase == LAST_CHIP);

    ca_code_nco #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_nco (
        .clk    (clk),
        .reset  (reset),
        .enable (w_nco_en),
        .clear  (load),
        .rate   (code_rate),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A zero target skips SLEW entirely. A slew ends on the edge that lands
    // on the target.
    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = (w_target_sat == 10'd0) ? ST_RUN : ST_SLEW;
        end else if ((r_state == ST_SLEW) && (w_phase_inc == r_target)) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_g1        <= LFSR_INIT;
            r_g2        <= LFSR_INIT;
            r_mask      <= MASK_PRN1;
            r_phase     <= '0;
            r_target    <= '0;
            r_half      <= 1'b0;
            r_early     <= 1'b0;
            r_prompt    <= 1'b0;
            r_late      <= 1'b0;
            r_epoch     <= 1'b0;
            r_epoch_cnt <= '0;
        end else begin
            r_epoch <= 1'b0;
            if (load) begin
                r_mask      <= prn_g2_mask(prn);
                r_g1        <= LFSR_INIT;
                r_g2        <= LFSR_INIT;
                r_phase     <= '0;
                r_target    <= w_target_sat;
                r_half      <= 1'b0;
                r_early     <= 1'b0;
                r_prompt    <= 1'b0;
                r_late      <= 1'b0;
                r_epoch_cnt <= '0;
            end else if (r_state == ST_SLEW) begin
                r_g1    <= w_g1_nxt;
                r_g2    <= w_g2_nxt;
                r_phase <= w_phase_inc;
            end else if (w_tick) begin
                r_late   <= r_prompt;
                r_prompt <= r_early;
                r_early  <= w_chip;
                r_half   <= ~r_half;
                // The chip advances only on the tick that closes its second half.
                if (r_half) begin
                    r_g1    <= w_g1_nxt;
                    r_g2    <= w_g2_nxt;
                    r_phase <= w_phase_inc;
                end
                if (w_wrap) begin
                    r_epoch     <= 1'b1;
                    r_epoch_cnt <= (r_epoch_cnt == EPOCH_W'(EPOCH_MOD - 1)) ?
                                   '0 : r_epoch_cnt + 1'b1;
                end
            end
        end
    end

    assign early       = r_early;
    assign prompt      = r_prompt;
    assign late        = r_late;
    assign code_phase  = r_phase;
    assign half_chip   = r_half;
    assign epoch       = r_epoch;
    assign epoch_count = r_epoch_cnt;
    assign busy        = (r_state == ST_SLEW);

endmodule
`default_nettype wire

// File: tb/tb_ca_code_nco_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ca_code_nco_gen
//  Description : Self-checking bench for ca_code_nco_gen. A chip-level
//                reference model builds each PRN's golden 1023-chip sequence
//                directly from the G1/G2 polynomial definitions. It tracks
//                phase, half-chip, NCO carry and E/P/L history with plain
//                arithmetic and is compared against the DUT on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ca_code_nco_gen;

    localparam int ACC_WIDTH = 24;
    localparam int EPOCH_MOD = 20;
    localparam int EPOCH_W   = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [ACC_WIDTH-1:0] code_rate;
    logic [4:0]           prn;
    logic                 load;
    logic [9:0]           load_phase;
    logic                 early, prompt, late;
    logic [9:0]           code_phase;
    logic                 half_chip;
    logic                 epoch;
    logic [EPOCH_W-1:0]   epoch_count;
    logic                 busy;

    ca_code_nco_gen #(
        .ACC_WIDTH (ACC_WIDTH),
        .EPOCH_MOD (EPOCH_MOD),
        .EPOCH_W   (EPOCH_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .code_rate   (code_rate),
        .prn         (prn),
        .load        (load),
        .load_phase  (load_phase),
        .early       (early),
        .prompt      (prompt),
        .late        (late),
        .code_phase  (code_phase),
        .half_chip   (half_chip),
        .epoch       (epoch),
        .epoch_count (epoch_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // G2 tap pairs for PRN1..PRN32 (stage numbers).
    int tap_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tap_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
    bit gold [1023];

    // Reference model state.
    int     m_phase, m_target, m_cnt;
    bit     m_half, m_e, m_p, m_l, m_epoch, m_busy;
    longint m_acc;

    function automatic void build_gold(input int p);
        bit s1 [1:10];
        bit s2 [1:10];
        bit f1, f2;
        for (int k = 1; k <= 10; k++) begin
            s1[k] = 1'b1;
            s2[k] = 1'b1;
        end
        for (int c = 0; c < 1023; c++) begin
            gold[c] = s1[10] ^ s2[tap_a[p]] ^ s2[tap_b[p]];
            f1 = s1[3] ^ s1[10];
            f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
            for (int k = 10; k > 1; k--) begin
                s1[k] = s1[k-1];
                s2[k] = s2[k-1];
            end
            s1[1] = f1;
            s2[1] = f2;
        end
    endfunction

    function automatic void model_reset();
        build_gold(0);
        m_phase = 0; m_target = 0; m_cnt = 0; m_acc = 0;
        m_half = 0; m_e = 0; m_p = 0; m_l = 0; m_epoch = 0; m_busy = 0;
    endfunction

    function automatic void model_step();
        longint s;
        longint modv;
        modv = longint'(1) << ACC_WIDTH;
        m_epoch = 0;
        if (load) begin
            build_gold(int'(prn));
            m_phase = 0; m_acc = 0; m_half = 0; m_cnt = 0;
            m_e = 0; m_p = 0; m_l = 0;
            m_target = (int'(load_phase) > 1022) ? 1022 : int'(load_phase);
            m_busy = (m_target != 0);
        end else if (m_busy) begin
            m_phase = m_phase + 1;
            if (m_phase == m_target) m_busy = 0;
        end else if (enable) begin
            s = m_acc + longint'(code_rate);
            m_acc = s % modv;
            if (s >= modv) begin
                m_l = m_p;
                m_p = m_e;
                m_e = gold[m_phase];
                if (m_half) begin
                    m_phase = (m_phase + 1) % 1023;
                    if (m_phase == 0) begin
                        m_epoch = 1;
                        m_cnt = (m_cnt + 1) % EPOCH_MOD;
                    end
                end
                m_half = !m_half;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        checks++;
        if (early !== m_e || prompt !== m_p || late !== m_l ||
            code_phase !== 10'(m_phase) || half_chip !== m_half ||
            epoch !== m_epoch || epoch_count !== EPOCH_W'(m_cnt) || busy !== m_busy) begin
            errors++;
            $display("FAIL %s t=%0t: got e%0b p%0b l%0b ph%0d h%0b ep%0b cnt%0d busy%0b, expected e%0b p%0b l%0b ph%0d h%0b ep%0b cnt%0d busy%0b",
                     tag, $time, early, prompt, late, code_phase, half_chip, epoch, epoch_count, busy,
                     m_e, m_p, m_l, m_phase, m_half, m_epoch, m_cnt, m_busy);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: model sees the inputs present at the edge; compare 1 after.
    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check_all("cycle");
    endtask

    task automatic do_load(input int p, input int ph);
        prn = 5'(p);
        load_phase = 10'(ph);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    // Returns the number of sampled cycles with busy high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1100) begin
            n++;
            cyc();
        end
    endtask

    function automatic logic [20:0] outs();
        return {early, prompt, late, code_phase, half_chip, epoch, epoch_count, busy};
    endfunction

    typedef struct {
        int prn;
        int phase;
        bit en;
        int exp_busy;
        int exp_phase;
    } ld_vec_t;

    ld_vec_t tbl [6];

    initial begin
        int n, got_chips, epochs, viol;
        logic [9:0] chips;
        bit prev_half;
        bit q [$];
        logic [20:0] snap;

        tbl[0] = '{prn: 0,  phase: 0,    en: 1'b1, exp_busy: 0,    exp_phase: 0};
        tbl[1] = '{prn: 22, phase: 500,  en: 1'b1, exp_busy: 500,  exp_phase: 500};
        tbl[2] = '{prn: 5,  phase: 1023, en: 1'b0, exp_busy: 1022, exp_phase: 1022};
        tbl[3] = '{prn: 31, phase: 1,    en: 1'b0, exp_busy: 1,    exp_phase: 1};
        tbl[4] = '{prn: 7,  phase: 1022, en: 1'b1, exp_busy: 1022, exp_phase: 1022};
        tbl[5] = '{prn: 13, phase: 37,   en: 1'b1, exp_busy: 37,   exp_phase: 37};

        reset = 1'b1; enable = 1'b0; load = 1'b0;
        code_rate = '0; prn = '0; load_phase = '0;
        model_reset();
        cyc();
        cyc();
        check("reset_outputs", int'(outs()), 0);
        reset = 1'b0;

        // First ten prompt chips of PRN1 at half-rate: a tick every 2 clocks.
        code_rate = ACC_WIDTH'(1) << (ACC_WIDTH - 1);
        enable = 1'b1;
        do_load(0, 0);
        check("load0_busy", int'(busy), 0);
        prev_half = half_chip;
        got_chips = 0; chips = '0; n = 0;
        while (got_chips < 10 && n < 200) begin
            n++;
            cyc();
            if (prev_half && !half_chip) begin
                chips = {chips[8:0], prompt};
                got_chips++;
            end
            prev_half = half_chip;
        end
        check("prn1_first10", int'(chips), 'o1440);
        check("tick_spacing_cycles", n, 40);

        // One full code period at half rate, with E/P/L spacing checks.
        do_load(0, 0);
        epochs = 0; viol = 0;
        prev_half = half_chip;
        q.delete();
        for (int i = 0; i < 4100; i++) begin
            cyc();
            if (epoch) epochs++;
            if (half_chip != prev_half) begin
                q.push_back(early);
                if (q.size() > 3) void'(q.pop_front());
                if (q.size() == 3 && (prompt !== q[1] || late !== q[0])) viol++;
            end
            prev_half = half_chip;
        end
        check("epoch_pulses_one_period", epochs, 1);
        check("epoch_count_one", int'(epoch_count), 1);
        check("epl_spacing_violations", viol, 0);

        // Remaining epochs at near one tick per clock; counter must wrap to 0.
        code_rate = '1;
        n = 0;
        while (epochs < 20 && n < 60000) begin
            n++;
            cyc();
            if (epoch) epochs++;
        end
        check("epochs_seen", epochs, 20);
        check("epoch_count_wrap", int'(epoch_count), 0);

        // Table of loads: slew length and landing phase.
        code_rate = ACC_WIDTH'(1) << (ACC_WIDTH - 1);
        foreach (tbl[i]) begin
            enable = tbl[i].en;
            do_load(tbl[i].prn, tbl[i].phase);
            count_busy(n);
            check($sformatf("slew_cycles_prn%0d", tbl[i].prn + 1), n, tbl[i].exp_busy);
            check($sformatf("slew_phase_prn%0d", tbl[i].prn + 1), int'(code_phase), tbl[i].exp_phase);
            enable = 1'b1;
            repeat (60) cyc();
        end

        // Reload mid-slew restarts from chip 0 toward the new target.
        do_load(3, 800);
        repeat (100) cyc();
        check("midslew_phase", int'(code_phase), 100);
        do_load(3, 300);
        check("reslew_restart_phase", int'(code_phase), 0);
        count_busy(n);
        check("reslew_cycles", n, 300);
        check("reslew_phase", int'(code_phase), 300);

        // Enable low mid-chip holds every output.
        code_rate = 24'h155555;
        do_load(4, 0);
        repeat (37) cyc();
        snap = outs();
        enable = 1'b0;
        repeat (50) cyc();
        check("enable_low_hold", int'(outs()), int'(snap));
        enable = 1'b1;
        repeat (30) cyc();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) code_rate = ACC_WIDTH'($urandom);
            if ($urandom_range(0, 99) < 2) begin
                do_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 1023)));
            end else begin
                cyc();
            end
        end

        // Asynchronous reset in the middle of a slew.
        enable = 1'b1;
        do_load(9, 900);
        repeat (50) cyc();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        check("async_reset_outputs", int'(outs()), 0);
        cyc();
        reset = 1'b0;
        code_rate = '1;
        repeat (200) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
